// File: rtl/vga_timing_gen_if.sv
// VGA raster timing bundle: run enable in, counters, syncs and strobes out.
// master = timing generator, slave = pixel pipeline consuming the raster.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          en;
  logic          pix_tick;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          draw;
  logic          fetch_req;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en,
    output pix_tick, hcount, vcount,
    output hsync, vsync, draw, fetch_req,
    output line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_tick, hcount, vcount,
    input  hsync, vsync, draw, fetch_req,
    input  line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v counters,
// syncs, draw window and a lead-ahead framebuffer fetch window.
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LEAD     = 2
) (
  input  logic clk,
  input  logic rst_n,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HA     = cnt_t'(H_ACTIVE);
  localparam cnt_t VA     = cnt_t'(V_ACTIVE);
  localparam cnt_t HS0    = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS1    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS0    = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS1    = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t HF_WR  = cnt_t'(H_TOTAL - LEAD);
  localparam cnt_t LEADC  = cnt_t'(LEAD);

  logic [DW-1:0] div;
  cnt_t h, v;
  logic hs, vs, dr, fr, ls, fs;

  logic tick, hwrap;
  cnt_t hn, vn, hf, vf;

  // Next position, plus the position LEAD ticks further on for fetch.
  always_comb begin
    tick  = vif.en && rst_n && (div == D_LAST);
    hwrap = (h == H_LAST);
    hn    = hwrap ? '0 : cnt_t'(h + 1'b1);
    vn    = v;
    if (hwrap)
      vn = (v == V_LAST) ? '0 : cnt_t'(v + 1'b1);
    if (hn >= HF_WR) begin
      hf = cnt_t'(hn - HF_WR);
      vf = (vn == V_LAST) ? '0 : cnt_t'(vn + 1'b1);
    end else begin
      hf = cnt_t'(hn + LEADC);
      vf = vn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
      h   <= H_LAST;
      v   <= V_LAST;
      hs  <= ~HS_POL;
      vs  <= ~VS_POL;
      dr  <= 1'b0;
      fr  <= 1'b0;
      ls  <= 1'b0;
      fs  <= 1'b0;
    end else begin
      if (vif.en)
        div <= (div == D_LAST) ? '0 : DW'(div + 1'b1);
      ls <= 1'b0;
      fs <= 1'b0;
      if (tick) begin
        h  <= hn;
        v  <= vn;
        hs <= (hn >= HS0 && hn < HS1) ? HS_POL : ~HS_POL;
        vs <= (vn >= VS0 && vn < VS1) ? VS_POL : ~VS_POL;
        dr <= (hn < HA) && (vn < VA);
        fr <= (hf < HA) && (vf < VA);
        ls <= hwrap;
        fs <= hwrap && (vn == '0);
      end
    end
  end

  assign vif.pix_tick    = tick;
  assign vif.hcount      = h;
  assign vif.vcount      = v;
  assign vif.hsync       = hs;
  assign vif.vsync       = vs;
  assign vif.draw        = dr;
  assign vif.fetch_req   = fr;
  assign vif.line_start  = ls && vif.en;
  assign vif.frame_start = fs && vif.en;
endmodule
